// File: rtl/uart_tx_fsm_ser_if.sv
// Transmit-side bus for uart_tx_fsm_ser: parallel byte, strobe, frame
// options and the serial line/busy status returned by the transmitter.
interface uart_tx_fsm_ser_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
   logic                  par_en;
   logic                  par_typ;
   logic [5:0]            prescalar;
   logic                  tx_out;
   logic                  busy;

   // Upstream side: supplies data and frame options, observes line/busy.
   modport master (
      output p_data, data_valid, par_en, par_typ, prescalar,
      input  tx_out, busy
   );

   // Transmitter side.
   modport slave (
      input  p_data, data_valid, par_en, par_typ, prescalar,
      output tx_out, busy
   );
endinterface

// File: rtl/uart_tx_fsm_ser.sv
// UART transmitter: serialises a latched byte LSB-first as
// start / data / optional parity / stop, each bit held for P clk cycles.
module uart_tx_fsm_ser #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   uart_tx_fsm_ser_if.slave        tx_if
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                state_q, state_n;
   logic [5:0]            edge_cnt_q, edge_cnt_n;
   logic [IDX_W-1:0]      bit_idx_q, bit_idx_n;
   logic [DATA_WIDTH-1:0] sh_data_q, sh_data_n;
   logic                  sh_par_en_q, sh_par_en_n;
   logic                  sh_par_typ_q, sh_par_typ_n;
   logic [5:0]            sh_presc_q, sh_presc_n;
   logic                  tx_q, tx_n;
   logic                  busy_q, busy_n;

   logic [5:0]            cnt_last;
   logic                  bit_done;
   logic                  par_bit;

   // Bit-period end marker and parity, both derived from the shadow copy only.
   always_comb begin
      cnt_last = (sh_presc_q == 6'd0) ? 6'd0 : (sh_presc_q - 6'd1);
      bit_done = (edge_cnt_q == cnt_last);
      par_bit  = (^sh_data_q) ^ sh_par_typ_q;
   end

   // Next-state and next-output logic; tx/busy are computed one edge ahead
   // so the start bit appears on the accepting edge.
   always_comb begin
      state_n      = state_q;
      edge_cnt_n   = edge_cnt_q;
      bit_idx_n    = bit_idx_q;
      sh_data_n    = sh_data_q;
      sh_par_en_n  = sh_par_en_q;
      sh_par_typ_n = sh_par_typ_q;
      sh_presc_n   = sh_presc_q;
      tx_n         = tx_q;
      busy_n       = busy_q;

      case (state_q)
         IDLE: begin
            tx_n       = 1'b1;
            busy_n     = 1'b0;
            edge_cnt_n = '0;
            bit_idx_n  = '0;
            if (tx_if.data_valid) begin
               sh_data_n    = tx_if.p_data;
               sh_par_en_n  = tx_if.par_en;
               sh_par_typ_n = tx_if.par_typ;
               sh_presc_n   = tx_if.prescalar;
               tx_n         = 1'b0;
               busy_n       = 1'b1;
               state_n      = START;
            end
         end

         START: begin
            if (bit_done) begin
               edge_cnt_n = '0;
               bit_idx_n  = '0;
               tx_n       = sh_data_q[0];
               state_n    = DATA;
            end else begin
               edge_cnt_n = edge_cnt_q + 6'd1;
            end
         end

         DATA: begin
            if (bit_done) begin
               edge_cnt_n = '0;
               if (bit_idx_q == LAST_IDX) begin
                  if (sh_par_en_q) begin
                     tx_n    = par_bit;
                     state_n = PARITY;
                  end else begin
                     tx_n    = 1'b1;
                     state_n = STOP;
                  end
               end else begin
                  bit_idx_n = bit_idx_q + 1'b1;
                  tx_n      = sh_data_q[bit_idx_n];
               end
            end else begin
               edge_cnt_n = edge_cnt_q + 6'd1;
            end
         end

         PARITY: begin
            if (bit_done) begin
               edge_cnt_n = '0;
               tx_n       = 1'b1;
               state_n    = STOP;
            end else begin
               edge_cnt_n = edge_cnt_q + 6'd1;
            end
         end

         STOP: begin
            if (bit_done) begin
               edge_cnt_n = '0;
               bit_idx_n  = '0;
               tx_n       = 1'b1;
               busy_n     = 1'b0;
               state_n    = IDLE;
            end else begin
               edge_cnt_n = edge_cnt_q + 6'd1;
            end
         end

         default: begin
            edge_cnt_n = '0;
            bit_idx_n  = '0;
            tx_n       = 1'b1;
            busy_n     = 1'b0;
            state_n    = IDLE;
         end
      endcase
   end

   // State, counters, shadow registers and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         edge_cnt_q   <= '0;
         bit_idx_q    <= '0;
         sh_data_q    <= '0;
         sh_par_en_q  <= 1'b0;
         sh_par_typ_q <= 1'b0;
         sh_presc_q   <= '0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_n;
         edge_cnt_q   <= edge_cnt_n;
         bit_idx_q    <= bit_idx_n;
         sh_data_q    <= sh_data_n;
         sh_par_en_q  <= sh_par_en_n;
         sh_par_typ_q <= sh_par_typ_n;
         sh_presc_q   <= sh_presc_n;
         tx_q         <= tx_n;
         busy_q       <= busy_n;
      end
   end

   assign tx_if.tx_out = tx_q;
   assign tx_if.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_fsm_ser.sv
// Directed bench for uart_tx_fsm_ser: expected {tx_out,busy} per cycle is
// queued when a frame is launched and popped/compared every cycle.
module tb_uart_tx_fsm_ser;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   uart_tx_fsm_ser_if #(.DATA_WIDTH(8)) bus ();

   uart_tx_fsm_ser #(.DATA_WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .tx_if (bus)
   );

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;
   logic [1:0]  sbq[$];

   // Compare {tx_out, busy} against an expected pair.
   task automatic check(input string tag, input logic [1:0] exp);
      logic [1:0] got;
      got = {bus.tx_out, bus.busy};
      vectors++;
      assert (got === exp)
      else begin
         miscompares++;
         $error("FAIL %s: {tx_out,busy} got %b expected %b (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Queue the per-cycle line/busy pattern of one frame plus one idle cycle.
   task automatic push_frame(input logic [7:0] data, input logic pe,
                             input logic pt, input logic [5:0] presc);
      int unsigned p;
      logic        bits[$];
      p = (presc == 6'd0) ? 1 : int'(presc);
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(data[i]);
      if (pe) bits.push_back((^data) ^ pt);
      bits.push_back(1'b1);
      foreach (bits[b])
         for (int unsigned k = 0; k < p; k++) sbq.push_back({bits[b], 1'b1});
      sbq.push_back(2'b10);
   endtask

   // Launch a frame at the current negedge and check it cycle by cycle.
   // inject_idx: pulse a conflicting request mid-frame; abort_idx: reset mid-frame.
   task automatic send(input string tag, input logic [7:0] data, input logic pe,
                       input logic pt, input logic [5:0] presc,
                       input int inject_idx, input int abort_idx);
      logic [1:0] exp;
      int         i;
      push_frame(data, pe, pt, presc);
      bus.p_data     = data;
      bus.par_en     = pe;
      bus.par_typ    = pt;
      bus.prescalar  = presc;
      bus.data_valid = 1'b1;
      i = 0;
      while (sbq.size() > 0) begin
         @(negedge clk);
         bus.data_valid = 1'b0;
         exp = sbq.pop_front();
         check(tag, exp);
         if (i == inject_idx) begin
            bus.data_valid = 1'b1;
            bus.p_data     = 8'h55;
            bus.par_en     = ~pe;
            bus.par_typ    = ~pt;
            bus.prescalar  = 6'd3;
         end
         if (i == abort_idx) begin
            rst = 1'b0;
            @(negedge clk);
            check({tag, "_rst"}, 2'b10);
            rst = 1'b1;
            sbq.delete();
         end
         i++;
      end
   endtask

   initial begin
      bus.p_data     = '0;
      bus.data_valid = 1'b0;
      bus.par_en     = 1'b0;
      bus.par_typ    = 1'b0;
      bus.prescalar  = 6'd1;

      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset", 2'b10);
      bus.data_valid = 1'b1;
      @(negedge clk);
      check("reset_valid", 2'b10);
      bus.data_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("idle", 2'b10);

      send("a5_p8",      8'hA5, 1'b0, 1'b0, 6'd8,  -1, -1);
      send("37_even",    8'h37, 1'b1, 1'b0, 6'd16, -1, -1);
      send("37_odd",     8'h37, 1'b1, 1'b1, 6'd16, -1, -1);
      send("busy_ign",   8'hC3, 1'b0, 1'b0, 6'd4,  13, -1);
      send("b2b_01",     8'h01, 1'b0, 1'b0, 6'd4,  -1, -1);
      send("b2b_fe",     8'hFE, 1'b0, 1'b0, 6'd4,  -1, -1);
      send("abort",      8'h5A, 1'b0, 1'b0, 6'd4,  -1, 17);
      send("post_abort", 8'h96, 1'b1, 1'b1, 6'd4,  -1, -1);
      send("presc0",     8'hFF, 1'b0, 1'b0, 6'd0,  -1, -1);
      send("presc1_par", 8'h80, 1'b1, 1'b0, 6'd1,  -1, -1);
      send("presc63",    8'h3C, 1'b0, 1'b0, 6'd63, -1, -1);

      repeat (3) begin
         @(negedge clk);
         check("tail_idle", 2'b10);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx_fsm_ser.md
Name: uart_tx_fsm_ser

Overview:
- UART transmitter: the transmit-side counterpart of the UART RX path.
- Accepts a parallel byte with a one-cycle valid strobe and serializes it LSB-first: start bit, data bits, optional parity bit, one stop bit.
- Each bit is held for a programmable number of clk cycles (prescalar), so TX runs on the same oversampled clock and prescale setting as RX.
- Sits between the system-side TX FIFO/sync stage and the tx_out pin; busy throttles the upstream reader.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (bit counter sized as clog2(DATA_WIDTH)).

Ports:
- clk  input  1  system/UART oversampled clock, rising edge.
- rst  input  1  synchronous active-low reset.
- p_data  input  DATA_WIDTH  parallel data to send.
- data_valid  input  1  one-cycle strobe; p_data is valid in this cycle.
- par_en  input  1  1 = parity bit inserted between data and stop.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- prescalar  input  6  clk cycles per bit (legal 1..63; 0 treated as 1).
- tx_out  output  1  serial line, idles high; registered.
- busy  output  1  high while a frame is in progress; registered.

Behaviour:
- Reset
  - Sampled on a clk edge with rst=0: state=IDLE, tx_out=1, busy=0, all counters=0.
  - Reset mid-frame aborts the frame immediately; the line returns high on that same edge.
- Capture
  - In IDLE, an edge with data_valid=1 latches p_data, par_en, par_typ and prescalar into shadow registers.
  - The frame uses only the shadow values; input changes mid-frame have no effect.
  - Parity is computed from the latched data: even = XOR of the bits; odd = inverted XOR.
- Handshake
  - data_valid is accepted only when state=IDLE (busy=0). It is ignored while busy=1: no queueing and no corruption.
  - On the accepting edge: busy<=1, tx_out<=0 (start bit), state<=START. The start bit appears on the first edge, giving zero extra latency.
- States and transitions (edge_cnt counts 0..P-1, where P = latched prescalar, or 1 if the latched value is 0)
  - IDLE: tx_out=1, busy=0. On data_valid go to START.
  - START: tx_out=0 for P cycles. At edge_cnt==P-1: go to DATA, bit_idx=0, tx_out<=data[0].
  - DATA: tx_out=data[bit_idx] for P cycles per bit. At edge_cnt==P-1:
    - if bit_idx < DATA_WIDTH-1: increment bit_idx and drive the next bit;
    - else go to PARITY if par_en, otherwise to STOP.
  - PARITY: tx_out=parity bit for P cycles, then go to STOP.
  - STOP: tx_out=1 for P cycles. At edge_cnt==P-1: busy<=0, go to IDLE.
  - Unused encodings go to IDLE with tx_out=1 and busy=0.
- Frame timing
  - Length is (DATA_WIDTH+2)*P cycles, or (DATA_WIDTH+3)*P cycles with parity, measured from the accepting edge to the edge where busy falls.
  - Back-to-back: a data_valid asserted in the cycle right after busy falls is accepted, so at least one idle-high cycle separates frames.
- Counters
  - edge_cnt is 6 bits and resets to 0 on every bit boundary.
  - At P=1 each bit lasts exactly one cycle.
- Outputs
  - tx_out and busy are flop outputs with no combinational path from the inputs.

Test Plan:
- Reset, then p_data=8'hA5, par_en=0, prescalar=8, one data_valid pulse.
  - Required: tx_out = 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles; busy high for exactly 80 cycles; tx_out=1 afterwards.
- p_data=8'h37, par_en=1, par_typ=0, prescalar=16.
  - Required: parity bit = 1 (five ones, even parity); frame length 176 cycles.
- Same data with par_typ=1.
  - Required: parity bit = 0.
- data_valid pulses with 8'h55 while busy in DATA state.
  - Required: ignored; the original frame completes unchanged.
- Frame 1 (8'h01), then data_valid=1 (8'hFE) the cycle after busy falls, with prescalar=4.
  - Required: exactly one idle-high cycle, then the second start bit; both frames correct.
- rst=0 for one edge during bit 3 of a frame.
  - Required: tx_out=1 and busy=0 on that edge. A new data_valid after release starts a clean frame.
- prescalar=0, p_data=8'hFF, par_en=0.
  - Required: one cycle per bit; 10-cycle frame.
